// File: rtl/gpi_rx_filter.sv
// Multi-channel GPI receiver: IE gating, pad synchroniser, glitch-filter
// debounce, configurable edge detection, sticky status and combined interrupt.
module gpi_rx_filter #(
  parameter int unsigned NCH         = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NCH-1:0]     pad_di_i,
  input  logic [NCH-1:0]     ie_i,
  input  logic [CNT_W-1:0]   thresh_i,
  input  logic [2*NCH-1:0]   mode_i,
  input  logic [NCH-1:0]     irq_en_i,
  input  logic [NCH-1:0]     clr_i,
  output logic [NCH-1:0]     level_o,
  output logic [NCH-1:0]     edge_o,
  output logic [NCH-1:0]     status_o,
  output logic               irq_o
);

  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [NCH-1:0]   level_q;
  logic [NCH-1:0]   level_d1_q;
  logic [NCH-1:0]   edge_q;
  logic [NCH-1:0]   status_q;
  logic             irq_q;

  logic [NCH-1:0]   in_c;
  logic [NCH-1:0]   s_c;
  logic [NCH-1:0]   edge_next_c;
  logic [NCH-1:0]   status_next_c;

  // Gating ahead of the synchroniser, edge qualification and sticky status update
  always_comb begin
    in_c          = pad_di_i & ie_i;
    s_c           = sync_q[SYNC_STAGES-1];
    edge_next_c   = '0;
    for (int n = 0; n < int'(NCH); n++) begin
      edge_next_c[n] = (level_q[n] & ~level_d1_q[n] & mode_i[2*n]) |
                       (~level_q[n] & level_d1_q[n] & mode_i[2*n+1]);
    end
    // A new event outranks a coincident clear
    status_next_c = (status_q & ~clr_i) | edge_q;
  end

  // Synchroniser, debounce counters, edge/status/irq registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      for (int n = 0; n < int'(NCH); n++) cnt_q[n] <= '0;
      level_q    <= '0;
      level_d1_q <= '0;
      edge_q     <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync_q[0] <= in_c;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      for (int n = 0; n < int'(NCH); n++) begin
        if (s_c[n] == level_q[n]) begin
          cnt_q[n] <= '0;
        end else if (cnt_q[n] >= thresh_i) begin
          level_q[n] <= s_c[n];
          cnt_q[n]   <= '0;
        end else begin
          cnt_q[n] <= cnt_q[n] + CNT_W'(1);
        end
      end
      level_d1_q <= level_q;
      edge_q     <= edge_next_c;
      status_q   <= status_next_c;
      irq_q      <= |(status_next_c & irq_en_i);
    end
  end

  assign level_o  = level_q;
  assign edge_o   = edge_q;
  assign status_o = status_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_gpi_rx_filter.sv
// Directed bench for gpi_rx_filter with hand-computed expectations.
module tb_gpi_rx_filter;

  localparam int unsigned NCH   = 8;
  localparam int unsigned CNT_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [NCH-1:0]   pad_di_i;
  logic [NCH-1:0]   ie_i;
  logic [CNT_W-1:0] thresh_i;
  logic [2*NCH-1:0] mode_i;
  logic [NCH-1:0]   irq_en_i;
  logic [NCH-1:0]   clr_i;
  logic [NCH-1:0]   level_o;
  logic [NCH-1:0]   edge_o;
  logic [NCH-1:0]   status_o;
  logic             irq_o;

  int errors = 0;
  int checks = 0;

  gpi_rx_filter #(.NCH(NCH), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .pad_di_i (pad_di_i),
    .ie_i     (ie_i),
    .thresh_i (thresh_i),
    .mode_i   (mode_i),
    .irq_en_i (irq_en_i),
    .clr_i    (clr_i),
    .level_o  (level_o),
    .edge_o   (edge_o),
    .status_o (status_o),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int ecnt [NCH];

  initial begin
    // Reset with pads high and enabled
    rst_ni = 1'b0; pad_di_i = 8'hFF; ie_i = 8'hFF; thresh_i = 8'd3;
    mode_i = 16'h0F55; irq_en_i = 8'h00; clr_i = 8'h00;
    step(3);
    chk("rst_level",  32'(level_o),  32'h00);
    chk("rst_edge",   32'(edge_o),   32'h00);
    chk("rst_status", 32'(status_o), 32'h00);
    chk("rst_irq",    32'(irq_o),    32'h0);
    rst_ni = 1'b1;
    step(5);
    chk("lat_before", 32'(level_o), 32'h00);
    step(1);
    chk("lat_level",  32'(level_o), 32'hFF);
    chk("lat_noedge", 32'(edge_o),  32'h00);
    step(1);
    chk("lat_edge",   32'(edge_o),  32'h3F);
    step(1);
    chk("lat_edge_end", 32'(edge_o),   32'h00);
    chk("lat_status",   32'(status_o), 32'h3F);
    chk("lat_irq_off",  32'(irq_o),    32'h0);
    irq_en_i = 8'h01;
    step(1);
    chk("irq_enable_late", 32'(irq_o), 32'h1);

    // Return all pads low and clear
    pad_di_i = 8'h00;
    step(12);
    clr_i = 8'hFF; step(1); clr_i = 8'h00;
    chk("idle_level",  32'(level_o),  32'h00);
    chk("idle_status", 32'(status_o), 32'h00);
    chk("idle_irq",    32'(irq_o),    32'h0);

    // Glitch reject on ch0: 4 cycles rejected, 5 cycles accepted
    mode_i = 16'h0001; thresh_i = 8'd4; irq_en_i = 8'h01;
    pad_di_i = 8'h01; step(4); pad_di_i = 8'h00; step(10);
    chk("glitch4_level",  32'(level_o),  32'h00);
    chk("glitch4_status", 32'(status_o), 32'h00);
    pad_di_i = 8'h01; step(5); pad_di_i = 8'h00;
    step(1);
    chk("glitch5_pre",   32'(level_o), 32'h00);
    step(1);
    chk("glitch5_level", 32'(level_o), 32'h01);
    chk("glitch5_noedge",32'(edge_o),  32'h00);
    step(1);
    chk("glitch5_edge",  32'(edge_o),  32'h01);
    step(1);
    chk("glitch5_edge_end", 32'(edge_o),   32'h00);
    chk("glitch5_status",   32'(status_o), 32'h01);
    chk("glitch5_irq",      32'(irq_o),    32'h1);
    step(10);
    clr_i = 8'h01; step(1); clr_i = 8'h00;
    chk("glitch_clr_status", 32'(status_o), 32'h00);
    chk("glitch_clr_irq",    32'(irq_o),    32'h0);
    chk("glitch_fall_level", 32'(level_o),  32'h00);

    // Edge modes: ch1 rise, ch2 fall, ch3 both; square wave period 40
    thresh_i = 8'd2; mode_i = 16'h00E4;
    for (int n = 0; n < int'(NCH); n++) ecnt[n] = 0;
    for (int p = 0; p < 4; p++) begin
      pad_di_i = 8'h0E;
      repeat (20) begin
        step(1);
        for (int n = 0; n < int'(NCH); n++) ecnt[n] += int'(edge_o[n]);
      end
      pad_di_i = 8'h00;
      repeat (20) begin
        step(1);
        for (int n = 0; n < int'(NCH); n++) ecnt[n] += int'(edge_o[n]);
      end
    end
    repeat (20) begin
      step(1);
      for (int n = 0; n < int'(NCH); n++) ecnt[n] += int'(edge_o[n]);
    end
    chk("mode00_count", 32'(ecnt[0]), 32'd0);
    chk("rise_count",   32'(ecnt[1]), 32'd4);
    chk("fall_count",   32'(ecnt[2]), 32'd4);
    chk("both_count",   32'(ecnt[3]), 32'd8);
    chk("modes_status", 32'(status_o), 32'h0E);
    chk("modes_irq",    32'(irq_o),    32'h0);
    clr_i = 8'h0A; step(1); clr_i = 8'h00;
    irq_en_i = 8'h04;
    step(1);
    chk("ch2_status", 32'(status_o), 32'h04);
    chk("ch2_irq",    32'(irq_o),    32'h1);

    // Clear collides with a new ch2 falling edge: set wins
    pad_di_i = 8'h04; step(10);
    chk("ch2_rise_level",  32'(level_o),  32'h04);
    chk("ch2_rise_status", 32'(status_o), 32'h04);
    pad_di_i = 8'h00; step(6);
    chk("ch2_fall_edge", 32'(edge_o), 32'h04);
    clr_i = 8'h04; step(1); clr_i = 8'h00;
    chk("collide_status", 32'(status_o), 32'h04);
    chk("collide_irq",    32'(irq_o),    32'h1);
    clr_i = 8'h04; step(1); clr_i = 8'h00;
    chk("clear_status", 32'(status_o), 32'h00);
    chk("clear_irq",    32'(irq_o),    32'h0);

    // IE gating on ch4 with zero threshold, falling-edge mode
    mode_i = 16'h02E4; thresh_i = 8'd0; pad_di_i = 8'h10;
    step(5);
    chk("ie_level_high", 32'(level_o),  32'h10);
    chk("ie_rise_quiet", 32'(status_o), 32'h00);
    ie_i = 8'hEF;
    step(2);
    chk("ie_level_hold", 32'(level_o), 32'h10);
    step(1);
    chk("ie_level_low",  32'(level_o), 32'h00);
    step(1);
    chk("ie_fall_edge",  32'(edge_o),  32'h10);
    step(1);
    chk("ie_status",     32'(status_o), 32'h10);

    // Reset mid-count on ch5
    mode_i = 16'h06E4; thresh_i = 8'd200; pad_di_i = 8'h30;
    step(100);
    chk("mid_level", 32'(level_o), 32'h00);
    rst_ni = 1'b0; step(1); rst_ni = 1'b1;
    chk("mid_rst_level",  32'(level_o),  32'h00);
    chk("mid_rst_edge",   32'(edge_o),   32'h00);
    chk("mid_rst_status", 32'(status_o), 32'h00);
    chk("mid_rst_irq",    32'(irq_o),    32'h0);
    step(202);
    chk("restart_before", 32'(level_o), 32'h00);
    step(1);
    chk("restart_level",  32'(level_o), 32'h20);
    step(1);
    chk("restart_edge",   32'(edge_o),  32'h20);
    step(1);
    chk("restart_status", 32'(status_o), 32'h20);
    chk("restart_irq",    32'(irq_o),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
